// File: rtl/fifo_cfg_pkg.sv
// rtl/fifo_cfg_pkg.sv - shared read-mode type and default geometry for fifo_sync_cfg
package fifo_cfg_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - FIFO storage array, synchronous write and asynchronous read
module fifo_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Not reset: stale entries are never presented because reads are gated by occupancy.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_cfg.sv
// rtl/fifo_sync_cfg.sv - single-clock FIFO with selectable read mode and programmable thresholds
module fifo_sync_cfg
    import fifo_cfg_pkg::*;
#(
    parameter int         FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int         FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter fifo_mode_e MODE       = FIFO_STD,
    localparam int        AW         = $clog2(FIFO_DEPTH),
    localparam int        CW         = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [CW-1:0]         ae_thresh,
    input  logic [CW-1:0]         af_thresh,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  half_full,
    output logic                  almost_full,
    output logic                  full
);

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_C  = CW'(FIFO_DEPTH / 2);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         ae_eff;
    logic [CW-1:0]         af_eff;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [FIFO_WIDTH-1:0] ram_rdata;

    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign half_full    = (count_q >= HALF_C);
    assign ae_eff       = (ae_thresh > DEPTH_C) ? DEPTH_C : ae_thresh;
    assign af_eff       = (af_thresh > DEPTH_C) ? DEPTH_C : af_thresh;
    assign almost_empty = (count_q <= ae_eff);
    assign almost_full  = (count_q >= af_eff);

    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
            if (rd_accept) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_accept, rd_accept})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            wr_ack    <= wr_accept;
            overflow  <= wr_en && !wr_accept;
            underflow <= rd_en && !rd_accept;
        end
    end

    fifo_ram #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            assign data_out = empty ? '0 : ram_rdata;
            assign rd_valid = !empty;
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] data_q;
            logic                  valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_accept;
                    if (rd_accept) data_q <= ram_rdata;
                end
            end

            assign data_out = data_q;
            assign rd_valid = valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_cfg.sv
// tb/tb_fifo_sync_cfg.sv - random and directed checks of both read modes against a queue model
module tb_fifo_sync_cfg;
    import fifo_cfg_pkg::*;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  data_in = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [CW-1:0] ae_thresh = 4'd2;
    logic [CW-1:0] af_thresh = 4'd6;

    logic [W-1:0]  s_data, f_data;
    logic          s_valid, f_valid, s_ack, f_ack, s_ovf, f_ovf, s_udf, f_udf;
    logic [CW-1:0] s_count, f_count;
    logic          s_e, s_ae, s_hf, s_af, s_f;
    logic          f_e, f_ae, f_hf, f_af, f_f;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] std_data_e = '0;
    logic         std_valid_e = 1'b0;
    logic         wa_e = 1'b0, ov_e = 1'b0, ud_e = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_cfg #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .MODE(FIFO_STD)) u_std (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .ae_thresh(ae_thresh), .af_thresh(af_thresh),
        .data_out(s_data), .rd_valid(s_valid), .wr_ack(s_ack), .overflow(s_ovf),
        .underflow(s_udf), .count(s_count), .empty(s_e), .almost_empty(s_ae),
        .half_full(s_hf), .almost_full(s_af), .full(s_f)
    );

    fifo_sync_cfg #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .MODE(FIFO_FWFT)) u_fwft (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .ae_thresh(ae_thresh), .af_thresh(af_thresh),
        .data_out(f_data), .rd_valid(f_valid), .wr_ack(f_ack), .overflow(f_ovf),
        .underflow(f_udf), .count(f_count), .empty(f_e), .almost_empty(f_ae),
        .half_full(f_hf), .almost_full(f_af), .full(f_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        int ae_eff;
        int af_eff;
        logic [4:0] flags_e;
        n      = q.size();
        ae_eff = (int'(ae_thresh) > D) ? D : int'(ae_thresh);
        af_eff = (int'(af_thresh) > D) ? D : int'(af_thresh);
        flags_e = {n == 0, n <= ae_eff, n >= D / 2, n >= af_eff, n == D};
        check("std_count",  32'(s_count), 32'(n));
        check("std_flags",  32'({s_e, s_ae, s_hf, s_af, s_f}), 32'(flags_e));
        check("std_pulses", 32'({s_ack, s_ovf, s_udf}), 32'({wa_e, ov_e, ud_e}));
        check("std_valid",  32'(s_valid), 32'(std_valid_e));
        check("std_data",   32'(s_data), 32'(std_data_e));
        check("fwft_count", 32'(f_count), 32'(n));
        check("fwft_flags", 32'({f_e, f_ae, f_hf, f_af, f_f}), 32'(flags_e));
        check("fwft_pulses", 32'({f_ack, f_ovf, f_udf}), 32'({wa_e, ov_e, ud_e}));
        check("fwft_valid", 32'(f_valid), 32'(n > 0));
        check("fwft_data",  32'(f_data), (n > 0) ? 32'(q[0]) : 32'h0);
    endtask

    task automatic model_reset();
        q.delete();
        std_data_e  = '0;
        std_valid_e = 1'b0;
        wa_e = 1'b0;
        ov_e = 1'b0;
        ud_e = 1'b0;
    endtask

    task automatic cycle(input logic w, input logic r, input logic [W-1:0] d);
        int n;
        logic ra;
        logic wa;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        n  = q.size();
        ra = r && (n > 0);
        wa = w && ((n < D) || ra);
        wa_e = wa;
        ov_e = w && !wa;
        ud_e = r && !ra;
        std_valid_e = ra;
        if (ra) std_data_e = q.pop_front();
        if (wa) q.push_back(d);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;
        @(negedge clk);
        check_all();

        for (int i = 1; i <= 9; i++) cycle(1'b1, 1'b0, W'(i));
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, '0);

        for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, W'($urandom));
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, W'($urandom));
        for (int i = 0; i < D; i++) cycle(1'b0, 1'b1, '0);

        cycle(1'b1, 1'b1, 16'h55AA);
        cycle(1'b0, 1'b1, '0);

        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, W'($urandom));
        wr_en = 1'b1;
        rst   = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        wr_en = 1'b0;
        rst   = 1'b0;
        check_all();
        cycle(1'b1, 1'b0, 16'hABCD);
        cycle(1'b0, 1'b1, '0);

        af_thresh = 4'd12;
        for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, W'($urandom));
        ae_thresh = 4'd15;
        for (int i = 0; i < D; i++) cycle(1'b0, 1'b1, '0);

        for (int i = 0; i < 800; i++) begin
            int wp;
            if (i % 37 == 0) begin
                ae_thresh = CW'($urandom_range(0, 15));
                af_thresh = CW'($urandom_range(0, 15));
            end
            wp = ((i / 100) % 2 == 0) ? 70 : 30;
            cycle(32'($urandom_range(0, 99)) < 32'(wp), $urandom_range(0, 99) < 50, W'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
